// File: rtl/common.sv
// Shared types and constants for the writeback/commit stage.
package common;

    localparam int n_threads = 8;

    typedef logic [31:0] word_t;
    typedef logic [31:0] vptr_t;
    typedef logic [19:0] pptr_t;
    typedef logic [19:0] vpn_t;
    typedef logic [7:0]  ppn_t;
    typedef logic [4:0]  regid_t;
    typedef logic [2:0]  threadid_t;

    typedef enum logic [1:0] {
        TLBW_NONE = 2'd0,
        TLBW_ITLB = 2'd1,
        TLBW_DTLB = 2'd2
    } tlbwrite_t;

    // Exception cause codes written to rm2.
    localparam word_t exc_code_itlb_miss = 32'd1;
    localparam word_t exc_code_dtlb_miss = 32'd2;

    localparam word_t exchandler_pc = 32'h0000_0400;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } exc_fsm_t;

endpackage

// File: rtl/exc_state.sv
// Exception fence FSM plus the per-thread mode bit and rm0..rm2 save registers.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_NORMAL | any thread may commit; a TLB miss raises an exception
//   ST_EXC    | only the master thread commits, until it executes iret
module exc_state
    import common::*;
#(
    parameter int N_THREADS = n_threads
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           take_exc,
    input  threadid_t                      exc_thread,
    input  logic                           exc_itlb,
    input  word_t                          exc_pc,
    input  word_t                          exc_data,
    input  logic                           take_iret,
    input  threadid_t                      iret_thread,
    output logic                           in_exc,
    output threadid_t                      master,
    output logic [N_THREADS-1:0]           mode,
    output logic [N_THREADS-1:0][2:0][31:0] rm_q
);

    exc_fsm_t state_q;
    exc_fsm_t state_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter on an exception, leave only on the master's iret.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (take_exc) state_d = ST_EXC;
            ST_EXC:    if (take_iret && iret_thread == master) state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    // Master thread, supervisor bits and exception save registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            master <= '0;
            mode   <= '1;
            rm_q   <= '0;
        end else begin
            if (take_exc) begin
                master                 <= exc_thread;
                mode[exc_thread]       <= 1'b1;
                rm_q[exc_thread][0]    <= exc_pc;
                rm_q[exc_thread][1]    <= exc_itlb ? exc_pc : exc_data;
                rm_q[exc_thread][2]    <= exc_itlb ? exc_code_itlb_miss : exc_code_dtlb_miss;
            end
            if (take_iret) begin
                mode[iret_thread] <= 1'b0;
            end
        end
    end

    assign in_exc = (state_q == ST_EXC);

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: in-order commit per thread, replay, redirects and exception entry.
module stage_wb
    import common::*;
#(
    parameter int    N_THREADS = n_threads,
    parameter word_t BOOT_PC   = 32'h1000,
    parameter word_t EXC_PC    = exchandler_pc
) (
    input  logic                            clk,
    input  logic                            rst,
    input  threadid_t                       wb_thread,
    input  logic                            wb_isvalid,
    input  logic                            wb_itlb_miss,
    input  logic                            wb_dtlb_miss,
    input  regid_t                          wb_dst,
    input  word_t                           wb_pc,
    input  word_t                           wb_data,
    input  word_t                           wb_r2,
    input  word_t                           wb_mul,
    input  logic                            wb_isequal,
    input  logic                            wb_flag_mul,
    input  logic                            wb_flag_reg,
    input  logic                            wb_flag_jump,
    input  logic                            wb_flag_branch,
    input  logic                            wb_flag_iret,
    input  logic                            wb_flag_store,
    input  logic                            wb_flag_isbyte,
    input  tlbwrite_t                       wb_flag_tlbwrite,
    output logic                            rf_wen,
    output threadid_t                       rf_thread,
    output regid_t                          rf_dst,
    output word_t                           rf_data,
    output logic                            redirect_en,
    output threadid_t                       redirect_thread,
    output word_t                           redirect_pc,
    output logic                            store_en,
    output logic                            store_isbyte,
    output pptr_t                           store_addr,
    output word_t                           store_data,
    output logic                            itlb_wen,
    output logic                            dtlb_wen,
    output vpn_t                            tlbwrite_vpn,
    output ppn_t                            tlbwrite_ppn,
    output logic                            exc_en,
    output threadid_t                       exc_thread,
    output logic [N_THREADS-1:0]            mode,
    output logic [N_THREADS-1:0][31:0]      commit_pc,
    output logic [N_THREADS-1:0][2:0][31:0] rm_q
);

    logic      in_exc;
    threadid_t master;

    logic in_order, miss, fence, take_exc, commit, take_jump, take_iret;

    logic                       rf_wen_d, redirect_en_d, store_en_d, store_isbyte_d;
    logic                       itlb_wen_d, dtlb_wen_d, exc_en_d;
    threadid_t                  rf_thread_d, redirect_thread_d, exc_thread_d;
    regid_t                     rf_dst_d;
    word_t                      rf_data_d, redirect_pc_d, store_data_d;
    pptr_t                      store_addr_d;
    vpn_t                       tlbwrite_vpn_d;
    ppn_t                       tlbwrite_ppn_d;
    logic [N_THREADS-1:0][31:0] commit_pc_d;

    // A beat carrying a TLB miss never commits: it either raises an exception or replays.
    assign in_order  = (wb_pc == commit_pc[wb_thread]);
    assign miss      = wb_itlb_miss | wb_dtlb_miss;
    assign fence     = !in_exc || (wb_thread == master);
    assign take_exc  = in_order && !in_exc && miss;
    assign commit    = in_order && wb_isvalid && fence && !miss;
    assign take_jump = wb_flag_jump && (!wb_flag_branch || wb_isequal);
    assign take_iret = commit && wb_flag_iret;

    exc_state #(
        .N_THREADS(N_THREADS)
    ) u_exc_state (
        .clk        (clk),
        .rst        (rst),
        .take_exc   (take_exc),
        .exc_thread (wb_thread),
        .exc_itlb   (wb_itlb_miss),
        .exc_pc     (wb_pc),
        .exc_data   (wb_data),
        .take_iret  (take_iret),
        .iret_thread(wb_thread),
        .in_exc     (in_exc),
        .master     (master),
        .mode       (mode),
        .rm_q       (rm_q)
    );

    // Commit decision: compute next outputs and the updated commit pointer.
    always_comb begin
        rf_wen_d          = 1'b0;
        rf_thread_d       = '0;
        rf_dst_d          = '0;
        rf_data_d         = '0;
        redirect_en_d     = 1'b0;
        redirect_thread_d = '0;
        redirect_pc_d     = '0;
        store_en_d        = 1'b0;
        store_isbyte_d    = 1'b0;
        store_addr_d      = '0;
        store_data_d      = '0;
        itlb_wen_d        = 1'b0;
        dtlb_wen_d        = 1'b0;
        tlbwrite_vpn_d    = '0;
        tlbwrite_ppn_d    = '0;
        exc_en_d          = 1'b0;
        exc_thread_d      = '0;
        commit_pc_d       = commit_pc;

        if (take_exc) begin
            redirect_en_d          = 1'b1;
            redirect_thread_d      = wb_thread;
            redirect_pc_d          = EXC_PC;
            exc_en_d               = 1'b1;
            exc_thread_d           = wb_thread;
            commit_pc_d[wb_thread] = EXC_PC;
        end else if (commit) begin
            commit_pc_d[wb_thread] = wb_pc + 32'd4;
            if (wb_flag_reg) begin
                rf_wen_d    = 1'b1;
                rf_thread_d = wb_thread;
                rf_dst_d    = wb_dst;
                rf_data_d   = wb_flag_mul ? wb_mul : wb_data;
            end
            if (wb_flag_store) begin
                store_en_d     = 1'b1;
                store_isbyte_d = wb_flag_isbyte;
                store_addr_d   = wb_data[19:0];
                store_data_d   = wb_r2;
            end
            if (wb_flag_tlbwrite != TLBW_NONE) begin
                itlb_wen_d     = (wb_flag_tlbwrite == TLBW_ITLB);
                dtlb_wen_d     = (wb_flag_tlbwrite == TLBW_DTLB);
                tlbwrite_vpn_d = wb_data[19:0];
                tlbwrite_ppn_d = wb_r2[7:0];
            end
            if (wb_flag_iret) begin
                redirect_en_d          = 1'b1;
                redirect_thread_d      = wb_thread;
                redirect_pc_d          = rm_q[wb_thread][0];
                commit_pc_d[wb_thread] = rm_q[wb_thread][0];
            end else if (take_jump) begin
                redirect_en_d          = 1'b1;
                redirect_thread_d      = wb_thread;
                redirect_pc_d          = wb_data;
                commit_pc_d[wb_thread] = wb_data;
            end
        end else if (in_order) begin
            redirect_en_d     = 1'b1;
            redirect_thread_d = wb_thread;
            redirect_pc_d     = commit_pc[wb_thread];
        end
    end

    // Output and commit-pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen          <= 1'b0;
            rf_thread       <= '0;
            rf_dst          <= '0;
            rf_data         <= '0;
            redirect_en     <= 1'b0;
            redirect_thread <= '0;
            redirect_pc     <= '0;
            store_en        <= 1'b0;
            store_isbyte    <= 1'b0;
            store_addr      <= '0;
            store_data      <= '0;
            itlb_wen        <= 1'b0;
            dtlb_wen        <= 1'b0;
            tlbwrite_vpn    <= '0;
            tlbwrite_ppn    <= '0;
            exc_en          <= 1'b0;
            exc_thread      <= '0;
            commit_pc       <= {N_THREADS{BOOT_PC}};
        end else begin
            rf_wen          <= rf_wen_d;
            rf_thread       <= rf_thread_d;
            rf_dst          <= rf_dst_d;
            rf_data         <= rf_data_d;
            redirect_en     <= redirect_en_d;
            redirect_thread <= redirect_thread_d;
            redirect_pc     <= redirect_pc_d;
            store_en        <= store_en_d;
            store_isbyte    <= store_isbyte_d;
            store_addr      <= store_addr_d;
            store_data      <= store_data_d;
            itlb_wen        <= itlb_wen_d;
            dtlb_wen        <= dtlb_wen_d;
            tlbwrite_vpn    <= tlbwrite_vpn_d;
            tlbwrite_ppn    <= tlbwrite_ppn_d;
            exc_en          <= exc_en_d;
            exc_thread      <= exc_thread_d;
            commit_pc       <= commit_pc_d;
        end
    end

endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb with a per-thread commit model and per-cycle compare.
module tb_stage_wb;
    import common::*;

    localparam logic [31:0] BOOT = 32'h1000;
    localparam logic [31:0] EXCP = exchandler_pc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  wb_thread;
    logic        wb_isvalid, wb_itlb_miss, wb_dtlb_miss;
    logic [4:0]  wb_dst;
    logic [31:0] wb_pc, wb_data, wb_r2, wb_mul;
    logic        wb_isequal, wb_flag_mul, wb_flag_reg, wb_flag_jump, wb_flag_branch;
    logic        wb_flag_iret, wb_flag_store, wb_flag_isbyte;
    tlbwrite_t   wb_flag_tlbwrite;

    logic        rf_wen, redirect_en, store_en, store_isbyte, itlb_wen, dtlb_wen, exc_en;
    logic [2:0]  rf_thread, redirect_thread, exc_thread;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data, redirect_pc, store_data;
    logic [19:0] store_addr, tlbwrite_vpn;
    logic [7:0]  tlbwrite_ppn;
    logic [7:0]  mode;
    logic [7:0][31:0]      commit_pc;
    logic [7:0][2:0][31:0] rm_q;

    stage_wb dut (
        .clk(clk), .rst(rst),
        .wb_thread(wb_thread), .wb_isvalid(wb_isvalid), .wb_itlb_miss(wb_itlb_miss),
        .wb_dtlb_miss(wb_dtlb_miss), .wb_dst(wb_dst), .wb_pc(wb_pc), .wb_data(wb_data),
        .wb_r2(wb_r2), .wb_mul(wb_mul), .wb_isequal(wb_isequal), .wb_flag_mul(wb_flag_mul),
        .wb_flag_reg(wb_flag_reg), .wb_flag_jump(wb_flag_jump), .wb_flag_branch(wb_flag_branch),
        .wb_flag_iret(wb_flag_iret), .wb_flag_store(wb_flag_store), .wb_flag_isbyte(wb_flag_isbyte),
        .wb_flag_tlbwrite(wb_flag_tlbwrite),
        .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_dst(rf_dst), .rf_data(rf_data),
        .redirect_en(redirect_en), .redirect_thread(redirect_thread), .redirect_pc(redirect_pc),
        .store_en(store_en), .store_isbyte(store_isbyte), .store_addr(store_addr),
        .store_data(store_data), .itlb_wen(itlb_wen), .dtlb_wen(dtlb_wen),
        .tlbwrite_vpn(tlbwrite_vpn), .tlbwrite_ppn(tlbwrite_ppn), .exc_en(exc_en),
        .exc_thread(exc_thread), .mode(mode), .commit_pc(commit_pc), .rm_q(rm_q)
    );

    typedef struct {
        logic [2:0]  thr;
        logic        valid, imiss, dmiss;
        logic [4:0]  dst;
        logic [31:0] pc, data, r2, mul;
        logic        iseq, fmul, freg, fjump, fbranch, firet, fstore, fbyte;
        logic [1:0]  tlbw;
    } beat_t;

    typedef struct {
        logic        rf_wen, redir_en, st_en, st_byte, iw, dw, exc_en;
        logic [2:0]  rf_thr, redir_thr, exc_thr;
        logic [4:0]  rf_dst;
        logic [31:0] rf_data, redir_pc, st_data;
        logic [19:0] st_addr, vpn;
        logic [7:0]  ppn;
    } exp_t;

    // Architectural model: what each thread has committed so far.
    logic [31:0] m_pc   [8];
    logic        m_mode [8];
    logic [31:0] m_rm   [8][3];
    logic        m_exc;
    logic [2:0]  m_master;
    exp_t        e;

    int n_vec = 0;
    int n_err = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t nb(input logic [2:0] thr, input logic [31:0] pc, input logic valid);
        beat_t b;
        b = '{default: '0};
        b.thr = thr;
        b.pc = pc;
        b.valid = valid;
        return b;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 8; t++) begin
            m_pc[t] = BOOT;
            m_mode[t] = 1'b1;
            for (int k = 0; k < 3; k++) m_rm[t][k] = '0;
        end
        m_exc = 1'b0;
        m_master = '0;
        e = '{default: '0};
    endtask

    task automatic model_step(input beat_t b);
        logic is_miss;
        e = '{default: '0};
        is_miss = b.imiss | b.dmiss;
        if (b.pc != m_pc[b.thr]) return;
        if (is_miss && !m_exc) begin
            m_exc = 1'b1;
            m_master = b.thr;
            m_pc[b.thr] = EXCP;
            m_mode[b.thr] = 1'b1;
            m_rm[b.thr][0] = b.pc;
            m_rm[b.thr][1] = b.imiss ? b.pc : b.data;
            m_rm[b.thr][2] = b.imiss ? 32'd1 : 32'd2;
            e.redir_en = 1'b1; e.redir_thr = b.thr; e.redir_pc = EXCP;
            e.exc_en = 1'b1; e.exc_thr = b.thr;
        end else if (b.valid && !is_miss && (!m_exc || b.thr == m_master)) begin
            m_pc[b.thr] = b.pc + 32'd4;
            if (b.freg) begin
                e.rf_wen = 1'b1; e.rf_thr = b.thr; e.rf_dst = b.dst;
                e.rf_data = b.fmul ? b.mul : b.data;
            end
            if (b.fstore) begin
                e.st_en = 1'b1; e.st_byte = b.fbyte; e.st_addr = b.data[19:0]; e.st_data = b.r2;
            end
            if (b.tlbw == 2'd1 || b.tlbw == 2'd2) begin
                e.iw = (b.tlbw == 2'd1); e.dw = (b.tlbw == 2'd2);
                e.vpn = b.data[19:0]; e.ppn = b.r2[7:0];
            end
            if (b.firet) begin
                e.redir_en = 1'b1; e.redir_thr = b.thr; e.redir_pc = m_rm[b.thr][0];
                m_pc[b.thr] = m_rm[b.thr][0];
                m_mode[b.thr] = 1'b0;
                if (m_exc && b.thr == m_master) m_exc = 1'b0;
            end else if (b.fjump && (!b.fbranch || b.iseq)) begin
                e.redir_en = 1'b1; e.redir_thr = b.thr; e.redir_pc = b.data;
                m_pc[b.thr] = b.data;
            end
        end else begin
            e.redir_en = 1'b1; e.redir_thr = b.thr; e.redir_pc = m_pc[b.thr];
        end
    endtask

    task automatic drive(input beat_t b);
        wb_thread = b.thr; wb_isvalid = b.valid; wb_itlb_miss = b.imiss; wb_dtlb_miss = b.dmiss;
        wb_dst = b.dst; wb_pc = b.pc; wb_data = b.data; wb_r2 = b.r2; wb_mul = b.mul;
        wb_isequal = b.iseq; wb_flag_mul = b.fmul; wb_flag_reg = b.freg; wb_flag_jump = b.fjump;
        wb_flag_branch = b.fbranch; wb_flag_iret = b.firet; wb_flag_store = b.fstore;
        wb_flag_isbyte = b.fbyte; wb_flag_tlbwrite = tlbwrite_t'(b.tlbw);
    endtask

    // Drive on the falling edge; the result is visible two time units after the next rising edge.
    task automatic apply(input beat_t b);
        @(negedge clk);
        drive(b);
        model_step(b);
        @(posedge clk);
        #2;
    endtask

    // Per-cycle compare of every output against the model.
    always begin
        @(posedge clk);
        #1;
        if (check_en) begin
            chk("rf_wen", 32'(rf_wen), 32'(e.rf_wen));
            chk("rf_thread", 32'(rf_thread), 32'(e.rf_thr));
            chk("rf_dst", 32'(rf_dst), 32'(e.rf_dst));
            chk("rf_data", rf_data, e.rf_data);
            chk("redirect_en", 32'(redirect_en), 32'(e.redir_en));
            chk("redirect_thread", 32'(redirect_thread), 32'(e.redir_thr));
            chk("redirect_pc", redirect_pc, e.redir_pc);
            chk("store_en", 32'(store_en), 32'(e.st_en));
            chk("store_isbyte", 32'(store_isbyte), 32'(e.st_byte));
            chk("store_addr", 32'(store_addr), 32'(e.st_addr));
            chk("store_data", store_data, e.st_data);
            chk("itlb_wen", 32'(itlb_wen), 32'(e.iw));
            chk("dtlb_wen", 32'(dtlb_wen), 32'(e.dw));
            chk("tlbwrite_vpn", 32'(tlbwrite_vpn), 32'(e.vpn));
            chk("tlbwrite_ppn", 32'(tlbwrite_ppn), 32'(e.ppn));
            chk("exc_en", 32'(exc_en), 32'(e.exc_en));
            chk("exc_thread", 32'(exc_thread), 32'(e.exc_thr));
            for (int t = 0; t < 8; t++) begin
                chk($sformatf("mode[%0d]", t), 32'(mode[t]), 32'(m_mode[t]));
                chk($sformatf("commit_pc[%0d]", t), commit_pc[t], m_pc[t]);
                for (int k = 0; k < 3; k++)
                    chk($sformatf("rm%0d[%0d]", k, t), rm_q[t][k], m_rm[t][k]);
            end
        end
    end

    initial begin
        beat_t b;
        beat_t idle;
        idle = nb(3'd0, 32'hFFFF_FFFC, 1'b0);
        drive(idle);
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        chk("reset commit_pc[0]", commit_pc[0], 32'h1000);
        chk("reset commit_pc[7]", commit_pc[7], 32'h1000);
        chk("reset mode", 32'(mode), 32'h0000_00FF);
        chk("reset redirect_en", 32'(redirect_en), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        model_step(idle);
        check_en = 1'b1;
        @(posedge clk);
        #2;

        // T0 in-order register write
        b = nb(3'd0, 32'h1000, 1'b1); b.freg = 1'b1; b.dst = 5'd5; b.data = 32'hAB;
        apply(b);
        chk("t0 rf_wen", 32'(rf_wen), 32'h1);
        chk("t0 rf_dst", 32'(rf_dst), 32'h5);
        chk("t0 rf_data", rf_data, 32'hAB);
        chk("t0 commit_pc", commit_pc[0], 32'h1004);

        // T1 out-of-order beat
        b = nb(3'd1, 32'h1008, 1'b1); b.freg = 1'b1; b.dst = 5'd3; b.data = 32'h77;
        apply(b);
        chk("t1 ooo rf_wen", 32'(rf_wen), 32'h0);
        chk("t1 ooo redirect_en", 32'(redirect_en), 32'h0);
        chk("t1 ooo commit_pc", commit_pc[1], 32'h1000);

        // T2 taken branch
        b = nb(3'd2, 32'h1000, 1'b1); b.fjump = 1'b1; b.fbranch = 1'b1; b.iseq = 1'b1; b.data = 32'h2000;
        apply(b);
        chk("t2 taken redirect_en", 32'(redirect_en), 32'h1);
        chk("t2 taken redirect_pc", redirect_pc, 32'h2000);
        chk("t2 taken commit_pc", commit_pc[2], 32'h2000);

        // T5 not-taken branch
        b = nb(3'd5, 32'h1000, 1'b1); b.fjump = 1'b1; b.fbranch = 1'b1; b.iseq = 1'b0; b.data = 32'h3000;
        apply(b);
        chk("t5 nt redirect_en", 32'(redirect_en), 32'h0);
        chk("t5 nt commit_pc", commit_pc[5], 32'h1004);

        // T0 MUL result selected
        b = nb(3'd0, 32'h1004, 1'b1); b.freg = 1'b1; b.fmul = 1'b1; b.dst = 5'd9;
        b.data = 32'h11; b.mul = 32'hDEAD_BEEF;
        apply(b);
        chk("t0 mul rf_data", rf_data, 32'hDEAD_BEEF);

        // T6 in order but invalid: replay
        b = nb(3'd6, 32'h1000, 1'b0); b.freg = 1'b1;
        apply(b);
        chk("t6 replay redirect_pc", redirect_pc, 32'h1000);
        chk("t6 replay rf_wen", 32'(rf_wen), 32'h0);

        // T3 DTLB miss raises exception
        b = nb(3'd3, 32'h1000, 1'b1); b.dmiss = 1'b1; b.data = 32'h5123;
        apply(b);
        chk("t3 exc_en", 32'(exc_en), 32'h1);
        chk("t3 exc_thread", 32'(exc_thread), 32'h3);
        chk("t3 redirect_pc", redirect_pc, EXCP);
        chk("t3 rm1", rm_q[3][1], 32'h5123);
        chk("t3 rm2", rm_q[3][2], 32'h2);
        chk("t3 rm0", rm_q[3][0], 32'h1000);

        // T4 ITLB miss while in EXC: replay only
        b = nb(3'd4, 32'h1000, 1'b1); b.imiss = 1'b1;
        apply(b);
        chk("t4 miss exc_en", 32'(exc_en), 32'h0);
        chk("t4 miss redirect_pc", redirect_pc, 32'h1000);

        // T4 valid but fenced
        b = nb(3'd4, 32'h1000, 1'b1); b.freg = 1'b1; b.dst = 5'd1; b.data = 32'h44;
        apply(b);
        chk("t4 fenced rf_wen", 32'(rf_wen), 32'h0);

        // T3 master iret
        b = nb(3'd3, EXCP, 1'b1); b.firet = 1'b1; b.fjump = 1'b1; b.data = 32'h9999;
        apply(b);
        chk("t3 iret redirect_pc", redirect_pc, 32'h1000);
        chk("t3 iret mode", 32'(mode[3]), 32'h0);
        chk("t3 iret commit_pc", commit_pc[3], 32'h1000);

        // T4 commits now that the fence is open
        b = nb(3'd4, 32'h1000, 1'b1); b.freg = 1'b1; b.dst = 5'd1; b.data = 32'h44;
        apply(b);
        chk("t4 commit rf_wen", 32'(rf_wen), 32'h1);
        chk("t4 commit_pc", commit_pc[4], 32'h1004);

        // T7 ITLB miss, TLB fills from the handler, iret
        b = nb(3'd7, 32'h1000, 1'b0); b.imiss = 1'b1; b.data = 32'h1234;
        apply(b);
        chk("t7 rm1", rm_q[7][1], 32'h1000);
        chk("t7 rm2", rm_q[7][2], 32'h1);
        b = nb(3'd7, EXCP, 1'b1); b.tlbw = 2'd1; b.data = 32'h0012_3456; b.r2 = 32'h1AB;
        apply(b);
        chk("t7 itlb_wen", 32'(itlb_wen), 32'h1);
        chk("t7 vpn", 32'(tlbwrite_vpn), 32'h2_3456);
        chk("t7 ppn", 32'(tlbwrite_ppn), 32'hAB);
        b = nb(3'd7, EXCP + 32'd4, 1'b1); b.tlbw = 2'd2; b.data = 32'h000A_BCDE; b.r2 = 32'h77;
        apply(b);
        chk("t7 dtlb_wen", 32'(dtlb_wen), 32'h1);
        chk("t7 itlb_wen off", 32'(itlb_wen), 32'h0);
        b = nb(3'd7, EXCP + 32'd8, 1'b1); b.firet = 1'b1;
        apply(b);
        chk("t7 iret redirect_pc", redirect_pc, 32'h1000);

        // Store byte then asynchronous reset
        b = nb(3'd0, 32'h1008, 1'b1); b.fstore = 1'b1; b.fbyte = 1'b1; b.data = 32'h30; b.r2 = 32'h7F;
        apply(b);
        chk("store_en", 32'(store_en), 32'h1);
        chk("store_addr", 32'(store_addr), 32'h30);
        chk("store_data", store_data, 32'h7F);
        chk("store_isbyte", 32'(store_isbyte), 32'h1);

        #1;
        check_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("async rst store_en", 32'(store_en), 32'h0);
        chk("async rst store_data", store_data, 32'h0);
        chk("async rst commit_pc[0]", commit_pc[0], 32'h1000);
        chk("async rst mode", 32'(mode), 32'h0000_00FF);
        chk("async rst rm0[3]", rm_q[3][0], 32'h0);
        model_reset();

        @(negedge clk);
        b = nb(3'd1, 32'h1000, 1'b1); b.freg = 1'b1; b.dst = 5'd2; b.data = 32'h66;
        drive(b);
        @(posedge clk);
        #2;
        chk("in reset rf_wen", 32'(rf_wen), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        b = nb(3'd0, 32'h1000, 1'b1); b.freg = 1'b1; b.dst = 5'd7; b.data = 32'h55;
        drive(b);
        model_step(b);
        check_en = 1'b1;
        @(posedge clk);
        #2;
        chk("post rst rf_wen", 32'(rf_wen), 32'h1);
        chk("post rst rf_data", rf_data, 32'h55);
        chk("post rst commit_pc", commit_pc[0], 32'h1004);

        apply(idle);
        apply(idle);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
